time_set_ctrl: RTL

//  Front-panel sequencer for the digital clock: steps through RUN -> FMT -> HR -> MIN -> SEC -> RUN on mode presses.

---
 rtl/time_set_ctrl_if.sv | 23 ++
 rtl/time_set_ctrl.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/time_set_ctrl_if.sv
// rtl/time_set_ctrl_if.sv - front-panel inputs and time-set control outputs of time_set_ctrl
interface time_set_ctrl_if;
  logic       tick_1hz;
  logic       btn_mode;
  logic       btn_adj;
  logic       run_en;
  logic       toggle_1224;
  logic       inc_hour;
  logic       inc_min;
  logic       clr_sec;
  logic [2:0] field;
  logic       blink;

  modport master (
    output tick_1hz, btn_mode, btn_adj,
    input  run_en, toggle_1224, inc_hour, inc_min, clr_sec, field, blink
  );

  modport slave (
    input  tick_1hz, btn_mode, btn_adj,
    output run_en, toggle_1224, inc_hour, inc_min, clr_sec, field, blink
  );
endinterface

// File: rtl/time_set_ctrl.sv
// rtl/time_set_ctrl.sv - front-panel set-mode sequencer for the digital clock
// Optional AUTO_REPEAT_EN: adj held in HR/MIN auto-repeats after REPEAT_START ticks.
module time_set_ctrl #(
  parameter int TIMEOUT_S    = 10,
  parameter int REPEAT_START = 2
) (
  input  logic           clk,
  input  logic           rst,
  time_set_ctrl_if.slave ts
);
  typedef enum logic [2:0] {
    ST_RUN = 3'd0,
    ST_FMT = 3'd1,
    ST_HR  = 3'd2,
    ST_MIN = 3'd3,
    ST_SEC = 3'd4
  } state_t;

  state_t     r_state, w_state_nx;
  logic       r_mode_q, r_adj_q;
  logic [7:0] r_to, w_to_nx, w_to_inc;
  logic       r_blink, w_blink_nx;
  logic       r_run_en;
  logic [3:0] r_stb, w_stb_nx;
  logic [3:0] w_adj_stb;
  logic       w_mode_edge, w_adj_edge, w_set, w_timeout;
`ifdef AUTO_REPEAT_EN
  logic [3:0] r_hold, w_hold_nx;
`endif

  always_comb begin
    w_mode_edge = ts.btn_mode & ~r_mode_q;
    w_adj_edge  = ts.btn_adj & ~r_adj_q;
    w_to_inc    = (r_to == 8'hFF) ? r_to : r_to + 8'd1;
    w_set       = r_state inside {ST_FMT, ST_HR, ST_MIN, ST_SEC};
    w_state_nx  = r_state;
    w_blink_nx  = r_blink;
    w_to_nx     = r_to;
    w_stb_nx    = 4'b0000;
    w_timeout   = 1'b0;

    // strobe bits are {toggle_1224, inc_hour, inc_min, clr_sec}
    case (r_state)
      ST_FMT:  w_adj_stb = 4'b1000;
      ST_HR:   w_adj_stb = 4'b0100;
      ST_MIN:  w_adj_stb = 4'b0010;
      ST_SEC:  w_adj_stb = 4'b0001;
      default: w_adj_stb = 4'b0000;
    endcase

    if (!w_set) begin
      w_state_nx = (r_state == ST_RUN && w_mode_edge) ? ST_FMT : ST_RUN;
      w_blink_nx = (w_state_nx == ST_FMT);
      w_to_nx    = 8'd0;
    end else if (w_mode_edge) begin
      case (r_state)
        ST_FMT:  w_state_nx = ST_HR;
        ST_HR:   w_state_nx = ST_MIN;
        ST_MIN:  w_state_nx = ST_SEC;
        default: w_state_nx = ST_RUN;
      endcase
      w_blink_nx = (w_state_nx != ST_RUN);
      w_to_nx    = 8'd0;
    end else begin
      if (w_adj_edge) begin
        w_stb_nx = w_adj_stb;
        w_to_nx  = 8'd0;
      end
`ifdef AUTO_REPEAT_EN
      else if (ts.btn_adj) begin
        w_to_nx = 8'd0;
      end
`endif
      else if (ts.tick_1hz) begin
        w_to_nx   = w_to_inc;
        w_timeout = (w_to_inc >= 8'(TIMEOUT_S));
      end
`ifdef AUTO_REPEAT_EN
      if (ts.tick_1hz && ts.btn_adj && r_adj_q && r_hold >= 4'(REPEAT_START) &&
          (r_state inside {ST_HR, ST_MIN})) begin
        w_stb_nx = w_adj_stb;
      end
`endif
      if (w_timeout) begin
        w_state_nx = ST_RUN;
        w_blink_nx = 1'b0;
        w_to_nx    = 8'd0;
      end else if (ts.tick_1hz) begin
        w_blink_nx = ~r_blink;
      end
    end

`ifdef AUTO_REPEAT_EN
    w_hold_nx = r_hold;
    if (w_state_nx != r_state || !ts.btn_adj) begin
      w_hold_nx = 4'd0;
    end else if (ts.tick_1hz && r_adj_q && r_hold < 4'(REPEAT_START)) begin
      w_hold_nx = r_hold + 4'd1;
    end
`endif
  end

  // button history resets high so a button held through reset gives no edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_RUN;
      r_mode_q <= 1'b1;
      r_adj_q  <= 1'b1;
      r_to     <= 8'd0;
      r_blink  <= 1'b0;
      r_run_en <= 1'b1;
      r_stb    <= 4'b0000;
    end else begin
      r_state  <= w_state_nx;
      r_mode_q <= ts.btn_mode;
      r_adj_q  <= ts.btn_adj;
      r_to     <= w_to_nx;
      r_blink  <= w_blink_nx;
      r_run_en <= (w_state_nx == ST_RUN) || (w_state_nx == ST_FMT);
      r_stb    <= w_stb_nx;
    end
  end

`ifdef AUTO_REPEAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold <= 4'd0;
    end else begin
      r_hold <= w_hold_nx;
    end
  end
`endif

  assign ts.field       = r_state;
  assign ts.run_en      = r_run_en;
  assign ts.blink       = r_blink;
  assign ts.toggle_1224 = r_stb[3];
  assign ts.inc_hour    = r_stb[2];
  assign ts.inc_min     = r_stb[1];
  assign ts.clr_sec     = r_stb[0];
endmodule
